usb_fs_tx_arbiter: RTL and testbench

Shares the single full-speed USB packet transmitter between NUM_REQ requesters, e.g. the IN-endpoint data engine and the handshake (ACK/NAK/STALL) responder. It arbitrates pending requests with fixed-priority or round-robin selection. The winner's PID goes to the transmitter with a one-cycle start pulse, and the byte-pull handshake is muxed to the winner only. The grant is held until the transmitter reports end-of-packet; a watchdog covers the case where that never comes. It lives in the clk domain, alongside the protocol engine, on the clk side of the transmitter's clock-domain strobes.

---
 rtl/usb_fs_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_usb_fs_tx_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_tx_arbiter.sv
// Arbitrates the shared full-speed USB packet transmitter between NUM_REQ requesters.
// The grant is held from the start pulse until end-of-packet or watchdog abort, then a GAP cycle count runs before re-arbitration.
module usb_fs_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ROUND_ROBIN = 0,
  parameter int GAP_CYCLES  = 4,
  parameter int TIMEOUT     = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_pid,
  input  logic [NUM_REQ-1:0]   req_data_avail,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_data_get,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   abort,
  output logic                 tx_pkt_start,
  output logic [3:0]           tx_pid,
  output logic                 tx_data_avail,
  input  logic                 tx_data_get,
  output logic [7:0]           tx_data,
  input  logic                 tx_pkt_end,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [IW:0]   NR_W     = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] r_abort;
  logic               r_start;
  logic [3:0]         r_pid;
  logic               r_terr;
  logic [IW-1:0]      r_rr_ptr;
  logic [WW-1:0]      r_wd;
  logic [GW-1:0]      r_gap;

  logic               w_found;
  logic [IW-1:0]      w_win;
  logic [IW:0]        w_sum;
  logic [IW-1:0]      w_base;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [3:0]         w_pid;
  logic [7:0]         w_tx_data;

  // Scan requesters starting at the priority base; fixed mode always starts at lane 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_base  = (ROUND_ROBIN != 0) ? r_rr_ptr : '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, w_base} + (IW+1)'(k);
      if (w_sum >= NR_W) w_sum = w_sum - NR_W;
      if (!w_found && req[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
    w_pid           = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IW'(i)) w_pid = req_pid[4*i +: 4];
    end
  end

  // One-hot OR mux keyed on the registered grant: everything reads zero outside SEND.
  always_comb begin
    w_tx_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_tx_data = w_tx_data | req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_abort  <= '0;
      r_start  <= 1'b0;
      r_pid    <= '0;
      r_terr   <= 1'b0;
      r_rr_ptr <= '0;
      r_wd     <= '0;
      r_gap    <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
      r_abort <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_SEND;
            r_grant <= w_win_oh;
            r_start <= 1'b1;
            r_pid   <= w_pid;
            r_wd    <= '0;
            if (ROUND_ROBIN != 0) r_rr_ptr <= (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
          end
        end
        S_SEND: begin
          r_wd <= r_wd + 1'b1;
          // End-of-packet takes precedence over a watchdog expiring on the same edge.
          if (tx_pkt_end) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else if (r_wd == WD_LAST) begin
            r_abort <= r_grant;
            r_terr  <= 1'b1;
            r_grant <= '0;
            r_gap   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_gap <= r_gap + 1'b1;
          if (r_gap == GAP_LAST) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant         = r_grant;
  assign done          = r_done;
  assign abort         = r_abort;
  assign tx_pkt_start  = r_start;
  assign tx_pid        = r_pid;
  assign timeout_err   = r_terr;
  assign busy          = (r_state != S_IDLE);
  assign tx_data       = w_tx_data;
  assign tx_data_avail = |(req_data_avail & r_grant);
  assign req_data_get  = {NUM_REQ{tx_data_get}} & r_grant;

endmodule

// File: tb/tb_usb_fs_tx_arbiter.sv
// Directed bench for usb_fs_tx_arbiter: fixed-priority, short-timeout and round-robin instances.
module tb_usb_fs_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, req_data_avail;
  logic [7:0]  req_pid;
  logic [15:0] req_data;
  logic        tx_data_get, tx_pkt_end;

  logic [1:0]  a_get, a_grant, a_done, a_abort;
  logic        a_start, a_avail, a_busy, a_terr;
  logic [3:0]  a_pid;
  logic [7:0]  a_data;

  logic [1:0]  t_get, t_grant, t_done, t_abort;
  logic        t_start, t_avail, t_busy, t_terr;
  logic [3:0]  t_pid;
  logic [7:0]  t_data;

  logic [2:0]  rr_req, rr_avail;
  logic [11:0] rr_pid;
  logic [23:0] rr_data;
  logic        rr_get_in, rr_end;
  logic [2:0]  rr_get, rr_grant, rr_done, rr_abort;
  logic        rr_start, rr_tavail, rr_busy, rr_terr;
  logic [3:0]  rr_tpid;
  logic [7:0]  rr_tdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  usb_fs_tx_arbiter #(.NUM_REQ(2), .ROUND_ROBIN(0), .GAP_CYCLES(4), .TIMEOUT(4096)) dut_a (
    .clk(clk), .reset(reset), .req(req), .req_pid(req_pid), .req_data_avail(req_data_avail),
    .req_data(req_data), .req_data_get(a_get), .grant(a_grant), .done(a_done), .abort(a_abort),
    .tx_pkt_start(a_start), .tx_pid(a_pid), .tx_data_avail(a_avail), .tx_data_get(tx_data_get),
    .tx_data(a_data), .tx_pkt_end(tx_pkt_end), .busy(a_busy), .timeout_err(a_terr));

  usb_fs_tx_arbiter #(.NUM_REQ(2), .ROUND_ROBIN(0), .GAP_CYCLES(4), .TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .req(req), .req_pid(req_pid), .req_data_avail(req_data_avail),
    .req_data(req_data), .req_data_get(t_get), .grant(t_grant), .done(t_done), .abort(t_abort),
    .tx_pkt_start(t_start), .tx_pid(t_pid), .tx_data_avail(t_avail), .tx_data_get(tx_data_get),
    .tx_data(t_data), .tx_pkt_end(tx_pkt_end), .busy(t_busy), .timeout_err(t_terr));

  usb_fs_tx_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(1), .GAP_CYCLES(4), .TIMEOUT(4096)) dut_r (
    .clk(clk), .reset(reset), .req(rr_req), .req_pid(rr_pid), .req_data_avail(rr_avail),
    .req_data(rr_data), .req_data_get(rr_get), .grant(rr_grant), .done(rr_done), .abort(rr_abort),
    .tx_pkt_start(rr_start), .tx_pid(rr_tpid), .tx_data_avail(rr_tavail), .tx_data_get(rr_get_in),
    .tx_data(rr_tdata), .tx_pkt_end(rr_end), .busy(rr_busy), .timeout_err(rr_terr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [2:0] rr_exp_grant [4];
  logic [3:0] rr_exp_pid [4];

  initial begin
    rr_exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_exp_pid   = '{4'h1, 4'h2, 4'h3, 4'h1};

    reset = 1'b1; req = '0; req_pid = '0; req_data_avail = '0; req_data = '0;
    tx_data_get = 1'b0; tx_pkt_end = 1'b0;
    rr_req = '0; rr_pid = 12'h321; rr_avail = '0; rr_data = '0; rr_get_in = 1'b0; rr_end = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_grant", 32'(a_grant), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_pid", 32'(a_pid), 32'h0);
    chk("rst_start", 32'(a_start), 32'h0);
    chk("rst_terr", 32'(a_terr), 32'h0);
    chk("rst_txdata", 32'(a_data), 32'h0);

    // Single request on lane 1, end 20 cycles after start
    req = 2'b10; req_pid = 8'hA0;
    tick();
    chk("single_grant", 32'(a_grant), 32'h2);
    chk("single_start", 32'(a_start), 32'h1);
    chk("single_pid", 32'(a_pid), 32'hA);
    chk("single_busy", 32'(a_busy), 32'h1);
    tick();
    chk("single_start_once", 32'(a_start), 32'h0);
    repeat (18) tick();
    chk("single_no_done_yet", 32'(a_done), 32'h0);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0; req = 2'b00;
    chk("single_done", 32'(a_done), 32'h2);
    chk("single_grant_clr", 32'(a_grant), 32'h0);
    chk("single_busy_gap", 32'(a_busy), 32'h1);
    tick();
    chk("single_done_pulse", 32'(a_done), 32'h0);
    repeat (2) tick();
    chk("single_busy_gap_last", 32'(a_busy), 32'h1);
    tick();
    chk("single_busy_low", 32'(a_busy), 32'h0);

    // Data routing from lane 0 while lane 1 data toggles
    req = 2'b01; req_pid = 8'hA3; req_data_avail = 2'b11; req_data = 16'h5511;
    tick();
    chk("data_grant", 32'(a_grant), 32'h1);
    chk("data_pid", 32'(a_pid), 32'h3);
    chk("data_avail", 32'(a_avail), 32'h1);
    chk("data_b0", 32'(a_data), 32'h11);
    tx_data_get = 1'b1; req_data[15:8] = 8'hAA;
    #1;
    chk("data_get0", 32'(a_get), 32'h1);
    chk("data_b0_hold", 32'(a_data), 32'h11);
    tick();
    tx_data_get = 1'b0; req_data[7:0] = 8'h22;
    #1;
    chk("data_b1", 32'(a_data), 32'h22);
    chk("data_get_idle", 32'(a_get), 32'h0);
    tx_data_get = 1'b1; req_data[15:8] = 8'h55;
    #1;
    chk("data_get1", 32'(a_get), 32'h1);
    tick();
    tx_data_get = 1'b0; req_data[7:0] = 8'h33;
    #1;
    chk("data_b2", 32'(a_data), 32'h33);
    tx_data_get = 1'b1;
    #1;
    chk("data_get2", 32'(a_get), 32'h1);
    tick();
    tx_data_get = 1'b0; req_data_avail = 2'b10;
    #1;
    chk("data_avail_lane0_only", 32'(a_avail), 32'h0);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0; req = 2'b00;
    chk("data_done", 32'(a_done), 32'h1);
    chk("data_gap_txdata", 32'(a_data), 32'h0);
    repeat (4) tick();
    chk("data_idle", 32'(a_busy), 32'h0);
    req_data_avail = 2'b00;

    // Fixed priority, both lanes requesting, twice in a row
    req = 2'b11; req_pid = 8'h59;
    tick();
    chk("fixed1_grant", 32'(a_grant), 32'h1);
    chk("fixed1_pid", 32'(a_pid), 32'h9);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    chk("fixed1_done", 32'(a_done), 32'h1);
    repeat (4) tick();
    chk("fixed_gap_no_regrant", 32'(a_grant), 32'h0);
    tick();
    chk("fixed2_grant", 32'(a_grant), 32'h1);
    chk("fixed2_start", 32'(a_start), 32'h1);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0; req = 2'b00;
    chk("fixed2_done", 32'(a_done), 32'h1);
    repeat (4) tick();
    chk("fixed_idle", 32'(a_busy), 32'h0);

    // Stray transmitter strobes while idle
    tx_pkt_end = 1'b1; tx_data_get = 1'b1;
    #1;
    chk("stray_get", 32'(a_get), 32'h0);
    tick();
    chk("stray_done", 32'(a_done), 32'h0);
    chk("stray_busy", 32'(a_busy), 32'h0);
    tx_pkt_end = 1'b0; tx_data_get = 1'b0;

    // Reset in SEND cycle 5 with a coincident end strobe
    req = 2'b10; req_pid = 8'hA0;
    tick();
    chk("rstmid_grant", 32'(a_grant), 32'h2);
    repeat (4) tick();
    reset = 1'b1; tx_pkt_end = 1'b1;
    tick();
    reset = 1'b0; tx_pkt_end = 1'b0; req = 2'b00;
    chk("rstmid_grant0", 32'(a_grant), 32'h0);
    chk("rstmid_done", 32'(a_done), 32'h0);
    chk("rstmid_abort", 32'(a_abort), 32'h0);
    chk("rstmid_busy", 32'(a_busy), 32'h0);
    chk("rstmid_pid", 32'(a_pid), 32'h0);
    chk("rstmid_txdata", 32'(a_data), 32'h0);
    tick();
    chk("rstmid_no_done_after", 32'(a_done), 32'h0);

    // Timeout instance: end strobe on the expiring edge wins
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 2'b01; req_pid = 8'h03;
    tick();
    chk("to_var_start", 32'(t_start), 32'h1);
    repeat (15) tick();
    chk("to_var_no_abort_early", 32'(t_abort), 32'h0);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0; req = 2'b00;
    chk("to_var_done", 32'(t_done), 32'h1);
    chk("to_var_abort", 32'(t_abort), 32'h0);
    chk("to_var_terr", 32'(t_terr), 32'h0);
    repeat (4) tick();
    chk("to_var_idle", 32'(t_busy), 32'h0);

    // Timeout instance: no end strobe
    req = 2'b01;
    tick();
    chk("to_start", 32'(t_start), 32'h1);
    repeat (15) tick();
    chk("to_abort_early", 32'(t_abort), 32'h0);
    chk("to_grant_held", 32'(t_grant), 32'h1);
    tick();
    req = 2'b00;
    chk("to_abort", 32'(t_abort), 32'h1);
    chk("to_grant_clr", 32'(t_grant), 32'h0);
    chk("to_terr", 32'(t_terr), 32'h1);
    chk("to_no_done", 32'(t_done), 32'h0);
    tick();
    chk("to_abort_pulse", 32'(t_abort), 32'h0);
    repeat (4) tick();
    chk("to_terr_sticky", 32'(t_terr), 32'h1);
    chk("to_idle", 32'(t_busy), 32'h0);

    // Round-robin over three held requests
    rr_req = 3'b111;
    for (int p = 0; p < 4; p++) begin
      tick();
      chk($sformatf("rr%0d_grant", p), 32'(rr_grant), 32'(rr_exp_grant[p]));
      chk($sformatf("rr%0d_pid", p), 32'(rr_tpid), 32'(rr_exp_pid[p]));
      rr_end = 1'b1;
      tick();
      rr_end = 1'b0;
      chk($sformatf("rr%0d_done", p), 32'(rr_done), 32'(rr_exp_grant[p]));
      repeat (4) tick();
      chk($sformatf("rr%0d_gap_grant", p), 32'(rr_grant), 32'h0);
    end
    rr_req = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
